// File: rtl/vape_exec_tracker.sv
// rtl/vape_exec_tracker.sv - ER run tracker producing the EXEC flag read by attestation
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   pc                   current program counter
//   ER_min, ER_max       executable region bounds (inclusive)
//   irq                  CPU interrupt acknowledge
//   data_addr, data_wr   CPU data write port
//   dma_addr, dma_wr     DMA write port
//   mon_exec             exec flags from the upstream property monitors
//   exec                 final EXEC flag (high in DONE)
//   er_active            high while an ER run is in progress
//   viol_cause           sticky code of the last violation
//   viol_cnt             saturating violation count

module vape_exec_tracker #(
   parameter int N_MON       = 4,
   parameter bit IRQ_ALLOWED = 1'b0,
   parameter int CNT_W       = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [15:0]       pc,
   input  logic [15:0]       ER_min,
   input  logic [15:0]       ER_max,
   input  logic              irq,
   input  logic [15:0]       data_addr,
   input  logic              data_wr,
   input  logic [15:0]       dma_addr,
   input  logic              dma_wr,
   input  logic [N_MON-1:0]  mon_exec,
   output logic              exec,
   output logic              er_active,
   output logic [2:0]        viol_cause,
   output logic [CNT_W-1:0]  viol_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2,
      KILL = 2'd3
   } state_t;

   localparam logic [2:0] C_MON     = 3'd1;
   localparam logic [2:0] C_EXIT    = 3'd2;
   localparam logic [2:0] C_IRQ     = 3'd3;
   localparam logic [2:0] C_WR      = 3'd4;
   localparam logic [2:0] C_CFG     = 3'd5;
   localparam logic [2:0] C_BOUNDS  = 3'd6;

   state_t      state, state_nxt;
   logic [15:0] prev_pc, cfg_min, cfg_max;
   logic [2:0]  cause_nxt;
   logic        latch_cfg;

   logic mon_ok, in_er, er_wr, bad_bounds, cfg_chg, irq_kill, ill_exit;

   assign mon_ok     = &mon_exec;
   assign in_er      = (pc >= ER_min) && (pc <= ER_max);
   assign er_wr      = (data_wr && (data_addr >= ER_min) && (data_addr <= ER_max)) ||
                       (dma_wr  && (dma_addr  >= ER_min) && (dma_addr  <= ER_max));
   assign bad_bounds = (ER_min > ER_max);
   assign cfg_chg    = (ER_min != cfg_min) || (ER_max != cfg_max);
   assign irq_kill   = irq && !IRQ_ALLOWED;
   assign ill_exit   = !in_er && (prev_pc != ER_max);

   // cause_nxt is nonzero exactly when this cycle takes an edge into KILL,
   // so it doubles as the violation-count enable.
   always_comb begin
      state_nxt = state;
      cause_nxt = 3'd0;
      latch_cfg = 1'b0;
      case (state)
         IDLE, KILL: begin
            if ((pc == ER_min) && mon_ok && !bad_bounds && !er_wr) begin
               state_nxt = RUN;
               latch_cfg = 1'b1;
            end
         end
         RUN: begin
            if (cfg_chg)          cause_nxt = C_CFG;
            else if (bad_bounds)  cause_nxt = C_BOUNDS;
            else if (!mon_ok)     cause_nxt = C_MON;
            else if (er_wr)       cause_nxt = C_WR;
            else if (irq_kill)    cause_nxt = C_IRQ;
            else if (ill_exit)    cause_nxt = C_EXIT;

            if (cause_nxt != 3'd0) state_nxt = KILL;
            // leaving the ER without an illegal exit means prev_pc was ER_max
            else if (!in_er)       state_nxt = DONE;
         end
         DONE: begin
            if (cfg_chg)          cause_nxt = C_CFG;
            else if (!mon_ok)     cause_nxt = C_MON;
            else if (er_wr)       cause_nxt = C_WR;

            if (cause_nxt != 3'd0) begin
               state_nxt = KILL;
            end else if (pc == ER_min) begin
               state_nxt = RUN;
               latch_cfg = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         prev_pc    <= 16'h0000;
         cfg_min    <= 16'h0000;
         cfg_max    <= 16'h0000;
         viol_cause <= 3'd0;
         viol_cnt   <= '0;
      end else begin
         state   <= state_nxt;
         prev_pc <= pc;
         if (latch_cfg) begin
            cfg_min <= ER_min;
            cfg_max <= ER_max;
         end
         if (cause_nxt != 3'd0) begin
            viol_cause <= cause_nxt;
            if (viol_cnt != {CNT_W{1'b1}})
               viol_cnt <= viol_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign exec      = (state == DONE);
   assign er_active = (state == RUN);

endmodule

// File: doc/vape_exec_tracker.md
Name: vape_exec_tracker

Overview:
- Sits downstream of the per-property VAPE monitors, including the IVT protection monitor, whose one-bit exec outputs it consumes.
- Tracks one complete, legal run of the executable region (ER): entry at ER_min, exit via ER_max.
- Combines the run result with the monitor results into the single EXEC flag that attestation reads.
- Also keeps a sticky violation cause and a saturating violation counter for debug.

Parameters:
- N_MON, 4, number of monitor exec inputs combined (bit i = monitor i).
- IRQ_ALLOWED, 0, 1 = interrupts during an ER run are tolerated; 0 = an interrupt during a run kills it.
- CNT_W, 8, width of the violation counter.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- pc  input  16  current program counter.
- ER_min  input  16  ER first instruction address.
- ER_max  input  16  ER last instruction address.
- irq  input  1  CPU interrupt acknowledge.
- data_addr  input  16  CPU data address.
- data_wr  input  1  CPU data write strobe.
- dma_addr  input  16  DMA address.
- dma_wr  input  1  DMA write strobe.
- mon_exec  input  N_MON  exec flags from the upstream monitors.
- exec  output  1  final EXEC flag.
- er_active  output  1  high while in RUN.
- viol_cause  output  3  sticky code of the last violation.
- viol_cnt  output  CNT_W  saturating violation count.

Behaviour:
- Reset (async assert, sync release): state=IDLE, prev_pc=0, cfg_min/cfg_max=0, viol_cause=0, viol_cnt=0. Hence exec=0 and er_active=0.
- Output decode: exec = (state==DONE); er_active = (state==RUN). Both are pure decodes of the state register, so no glitches. An output changes in the cycle after the clock edge that takes the transition.
- States: IDLE, RUN, DONE, KILL (2-bit encoding).
- Internal conditions:
  - mon_ok = AND of all mon_exec bits.
  - in_er = (ER_min <= pc <= ER_max), unsigned compare.
  - er_wr = (data_wr and data_addr in ER) or (dma_wr and dma_addr in ER).
  - bad_bounds = (ER_min > ER_max).
  - cfg_chg = (ER_min != cfg_min or ER_max != cfg_max).
- cfg_min/cfg_max are latched on every entry to RUN.
- Transitions, evaluated per cycle:
  - IDLE or KILL -> RUN when pc==ER_min and mon_ok and !bad_bounds and !er_wr.
  - RUN -> KILL on any of: !mon_ok; er_wr; cfg_chg; bad_bounds; (irq and IRQ_ALLOWED==0); (!in_er and prev_pc!=ER_max), i.e. an illegal exit.
  - RUN -> DONE when !in_er and prev_pc==ER_max and no kill condition is present. A kill condition in the same cycle wins.
  - DONE -> KILL on !mon_ok, er_wr, or cfg_chg.
  - DONE -> RUN when pc==ER_min, re-execution. exec drops for the duration of the run.
  - Otherwise the state holds.
- prev_pc <= pc every cycle.
- Single-instruction ER (ER_min==ER_max): the entry cycle satisfies pc==ER_max, so an exit on the following cycle goes to DONE.
- Any transition into KILL:
  - viol_cnt increments, saturating at all-ones, no wrap.
  - viol_cause loads the highest-priority active cause.
- Cause codes and priority, highest first: 5 cfg_chg, 6 bad_bounds, 1 monitor, 4 ER write, 3 irq, 2 illegal exit. 0 = no violation since reset.
- viol_cause is not cleared by DONE.
- A remaining in KILL does not recount. Only the edge into KILL counts.
- Reset asserted mid-RUN or in DONE returns immediately to IDLE with exec=0. Counters clear.

Test Plan:
- Legal run: ER_min=0xE000, ER_max=0xE010, mon_exec=4'hF. pc walks 0xC000 -> 0xE000 ... 0xE010 -> 0xC100. Required: er_active=1 from the cycle after pc=0xE000; exec=1 the cycle after pc=0xC100; viol_cnt=0.
- Early exit: same setup, pc jumps 0xE004 -> 0xC100. Required: state KILL, exec=0, viol_cause=2, viol_cnt=1.
- Monitor drop after DONE: exec=1, then mon_exec=4'hE for 3 cycles. Required: exec=0 the cycle after the first drop; viol_cause=1; viol_cnt=1, not 3.
- DMA write into ER during RUN together with irq (IRQ_ALLOWED=0), same cycle. Required: KILL, viol_cause=4 (priority over irq); then pc=0xE000 with mon_ok re-enters RUN.
- ER_max changed to 0xE020 mid-run. Required: viol_cause=5. Separately, ER_min=0xF000 and ER_max=0xE000 at pc=0xF000: stays IDLE, never RUN.
- Force 300 violations with CNT_W=8: viol_cnt holds 8'hFF. Assert reset_n=0 asynchronously mid-RUN: exec=0, viol_cnt=0, state IDLE without a clock edge.
